// File: rtl/load_unit.sv
// load_unit: RV32I load path (LB/LH/LW/LBU/LHU).
// Issues a word-aligned read, waits for the memory ack with a timeout,
// then extracts and extends the addressed byte/halfword.
//
// Optional feature macro: LOAD_MISALIGN_TRAP_EN
//   defined   -> misaligned LH/LHU/LW abort to ERR without a memory request
//   undefined -> low address bits are ignored for LH/LHU/LW
//
// state | meaning
// IDLE  | waiting for op_for==001; latches address and funct3
// REQ   | read request outstanding; timeout counter running
// DONE  | load_valid_out pulse; result held in load_data_out
// ERR   | load_err_out pulse; load_data_out forced to 0
module load_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [2:0]  op_for,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  output logic        mem_rd_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        load_err_out,
  output logic        stall_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;

  logic             f3_bad;
  logic             misaligned;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      ext_data;

  // Classify the incoming load: unsupported funct3 or (optionally) misaligned
  always_comb begin
    f3_bad = 1'b1;
    case (funct3_in)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_bad = 1'b0;
      default:                                f3_bad = 1'b1;
    endcase
`ifdef LOAD_MISALIGN_TRAP_EN
    misaligned = ((funct3_in == 3'b001 || funct3_in == 3'b101) && addr_in[0]) ||
                 ((funct3_in == 3'b010) && (addr_in[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // Select the addressed byte/half from the returned word and extend it
  always_comb begin
    byte_sel = mem_data_in[7:0];
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_data_in[7:0];
      2'd1:    byte_sel = mem_data_in[15:8];
      2'd2:    byte_sel = mem_data_in[23:16];
      default: byte_sel = mem_data_in[31:24];
    endcase
    half_sel = addr_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];
    case (funct3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      default: ext_data = mem_data_in;
    endcase
  end

  // Next-state logic: accept, wait for ack or timeout, then pulse result
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (op_for == 3'b001) begin
          addr_d   = addr_in;
          funct3_d = funct3_in;
          cnt_d    = '0;
          if (f3_bad || misaligned) begin
            data_d  = '0;
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Ack wins over a timeout landing in the same cycle
        if (mem_ack_in) begin
          data_d  = ext_data;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // Request and pulses decode straight from state so reset drops them at once;
  // stall is masked during reset so a held load is only seen after release
  assign mem_rd_req_out = (state_q == S_REQ);
  assign mem_addr_out   = {addr_q[31:2], 2'b00};
  assign load_valid_out = (state_q == S_DONE);
  assign load_err_out   = (state_q == S_ERR);
  assign load_data_out  = data_q;
  assign stall_out      = !reset_in &&
                          (((state_q == S_IDLE) && (op_for == 3'b001)) || (state_q == S_REQ));

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit (TIMEOUT_CYCLES = 4).
// Expected load results come from an arithmetic reference model.
module tb_load_unit;
  localparam int TO = 4;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [2:0]  op_for;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic        mem_rd_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        load_err_out;
  logic        stall_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data;

  load_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .op_for(op_for), .funct3_in(funct3_in),
    .addr_in(addr_in), .mem_rd_req_out(mem_rd_req_out), .mem_addr_out(mem_addr_out),
    .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .load_err_out(load_err_out), .stall_out(stall_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: value a load returns, by plain arithmetic on the word
  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] data);
    longint v;
    int unsigned sh;
    case (f3)
      3'b000, 3'b100: begin
        sh = (addr % 4) * 8;
        v = (data >> sh) & 255;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        sh = ((addr % 4) / 2) * 16;
        v = (data >> sh) & 65535;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(data);
    endcase
    return 32'(v);
  endfunction

  function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] addr);
    bit ok;
    ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
`ifdef LOAD_MISALIGN_TRAP_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && (addr % 2) != 0) ok = 0;
    if (f3 == 3'b010 && (addr % 4) != 0) ok = 0;
`endif
    return ok;
  endfunction

  function automatic logic [2:0] nonload();
    logic [2:0] v;
    do v = 3'($urandom_range(0, 7)); while (v == 3'b001);
    return v;
  endfunction

  // One complete load; bench is at posedge+1 on entry and on exit
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int waits);
    logic [31:0] exp_d;
    logic [31:0] exp_a;
    bit leg;
    leg   = ref_legal(f3, addr);
    exp_d = ref_ext(f3, addr, data);
    exp_a = addr & 32'hFFFF_FFFC;
    op_for = 3'b001; funct3_in = f3; addr_in = addr; mem_ack_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (stall_out !== 1'b1 || mem_rd_req_out !== 1'b0 || load_valid_out !== 1'b0 || load_err_out !== 1'b0) begin
      errors++;
      $display("FAIL accept f3=%b addr=%h: stall=%b req=%b valid=%b err=%b, want 1 0 0 0",
               f3, addr, stall_out, mem_rd_req_out, load_valid_out, load_err_out);
    end
    @(posedge clk_in); #1;
    op_for = nonload(); funct3_in = 3'($urandom); addr_in = $urandom;
    if (!leg) begin
      @(negedge clk_in);
      checks++;
      if (load_err_out !== 1'b1 || load_valid_out !== 1'b0 || mem_rd_req_out !== 1'b0 ||
          load_data_out !== 32'd0 || stall_out !== 1'b0) begin
        errors++;
        $display("FAIL illegal_err f3=%b addr=%h: err=%b valid=%b req=%b data=%h stall=%b, want 1 0 0 0 0",
                 f3, addr, load_err_out, load_valid_out, mem_rd_req_out, load_data_out, stall_out);
      end
      last_data = 32'd0;
    end else begin
      for (int i = 0; i < ((waits >= TO) ? TO : waits); i++) begin
        mem_ack_in = 1'b0; mem_data_in = $urandom;
        @(negedge clk_in);
        checks++;
        if (mem_rd_req_out !== 1'b1 || mem_addr_out !== exp_a || stall_out !== 1'b1 ||
            load_valid_out !== 1'b0 || load_err_out !== 1'b0) begin
          errors++;
          $display("FAIL req_wait%0d addr=%h: req=%b maddr=%h stall=%b valid=%b err=%b, want 1 %h 1 0 0",
                   i, addr, mem_rd_req_out, mem_addr_out, stall_out, load_valid_out, load_err_out, exp_a);
        end
        @(posedge clk_in); #1;
      end
      if (waits >= TO) begin
        mem_ack_in = 1'($urandom); mem_data_in = $urandom;
        @(negedge clk_in);
        checks++;
        if (load_err_out !== 1'b1 || mem_rd_req_out !== 1'b0 || load_data_out !== 32'd0 ||
            stall_out !== 1'b0 || load_valid_out !== 1'b0) begin
          errors++;
          $display("FAIL timeout_err addr=%h: err=%b req=%b data=%h stall=%b valid=%b, want 1 0 0 0 0",
                   addr, load_err_out, mem_rd_req_out, load_data_out, stall_out, load_valid_out);
        end
        last_data = 32'd0;
      end else begin
        mem_ack_in = 1'b1; mem_data_in = data;
        @(negedge clk_in);
        checks++;
        if (mem_rd_req_out !== 1'b1 || mem_addr_out !== exp_a || stall_out !== 1'b1) begin
          errors++;
          $display("FAIL req_ack addr=%h: req=%b maddr=%h stall=%b, want 1 %h 1",
                   addr, mem_rd_req_out, mem_addr_out, stall_out, exp_a);
        end
        @(posedge clk_in); #1;
        mem_ack_in = 1'($urandom); mem_data_in = $urandom;
        @(negedge clk_in);
        checks++;
        if (load_valid_out !== 1'b1 || load_data_out !== exp_d || stall_out !== 1'b0 ||
            mem_rd_req_out !== 1'b0 || load_err_out !== 1'b0) begin
          errors++;
          $display("FAIL done f3=%b addr=%h data=%h: valid=%b out=%h stall=%b req=%b err=%b, want 1 %h 0 0 0",
                   f3, addr, data, load_valid_out, load_data_out, stall_out, mem_rd_req_out,
                   load_err_out, exp_d);
        end
        last_data = exp_d;
      end
    end
    @(posedge clk_in); #1;
    mem_ack_in = 1'b0;
  endtask

  // Quiet cycle: no pulses, result held, stray ack ignored
  task automatic idle_check();
    op_for = nonload(); mem_ack_in = 1'($urandom); mem_data_in = $urandom;
    @(negedge clk_in);
    checks++;
    if (load_valid_out !== 1'b0 || load_err_out !== 1'b0 || mem_rd_req_out !== 1'b0 ||
        stall_out !== 1'b0 || load_data_out !== last_data) begin
      errors++;
      $display("FAIL idle_hold: valid=%b err=%b req=%b stall=%b data=%h, want 0 0 0 0 %h",
               load_valid_out, load_err_out, mem_rd_req_out, stall_out, load_data_out, last_data);
    end
    @(posedge clk_in); #1;
    mem_ack_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; op_for = 3'b001; funct3_in = 3'b010; addr_in = 32'h40;
    mem_ack_in = 1'b1; mem_data_in = 32'hDEAD_BEEF;
    #12;
    checks++;
    if (mem_rd_req_out !== 1'b0 || load_valid_out !== 1'b0 || load_err_out !== 1'b0 ||
        load_data_out !== 32'd0 || mem_addr_out !== 32'd0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: req=%b valid=%b err=%b data=%h maddr=%h stall=%b, want all 0",
               mem_rd_req_out, load_valid_out, load_err_out, load_data_out, mem_addr_out, stall_out);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_stall: stall=%b, want 1", stall_out);
    end
    op_for = 3'b000; mem_ack_in = 1'b0;
    last_data = 32'd0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_directed();
    do_load(3'b000, 32'h0000_0103, 32'h80FF_1234, 0);   // LB -> FFFFFF80
    idle_check();
    do_load(3'b101, 32'h0000_0202, 32'h8001_7FFF, 3);   // LHU -> 00008001
    do_load(3'b001, 32'h0000_0202, 32'h8001_7FFF, 3);   // LH  -> FFFF8001
    idle_check();
  endtask

  task automatic test_timeout();
    do_load(3'b010, 32'h0000_0400, 32'h1234_5678, TO);
    do_load(3'b100, 32'h0000_0405, 32'hA5C3_7E01, 0);   // accepted right after ERR
    idle_check();
  endtask

  task automatic test_illegal();
    do_load(3'b011, 32'h0000_0100, 32'h1111_1111, 0);
    do_load(3'b010, 32'h0000_0101, 32'hCAFE_F00D, 0);   // err if trapping, else word
    do_load(3'b001, 32'h0000_0103, 32'hBEEF_8123, 1);
    idle_check();
  endtask

  task automatic test_reset_mid_req();
    op_for = 3'b001; funct3_in = 3'b010; addr_in = 32'h0000_0040; mem_ack_in = 1'b0;
    @(posedge clk_in); #1;
    op_for = 3'b000;
    @(negedge clk_in);
    #1 reset_in = 1'b1;
    #1;
    checks++;
    if (mem_rd_req_out !== 1'b0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_req: req=%b stall=%b, want 0 0", mem_rd_req_out, stall_out);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    mem_ack_in = 1'b1; mem_data_in = 32'h7777_7777;
    last_data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      @(negedge clk_in);
      checks++;
      if (load_valid_out !== 1'b0 || load_err_out !== 1'b0 || mem_rd_req_out !== 1'b0 ||
          load_data_out !== 32'd0) begin
        errors++;
        $display("FAIL late_ack%0d: valid=%b err=%b req=%b data=%h, want 0 0 0 0",
                 i, load_valid_out, load_err_out, mem_rd_req_out, load_data_out);
      end
    end
    mem_ack_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_back_to_back();
    do_load(3'b010, 32'h0000_0300, 32'h0BAD_CAFE, 0);
    do_load(3'b010, 32'h0000_0304, 32'hF00D_1234, 1);
    idle_check();
  endtask

  task automatic test_random();
    logic [2:0] f3s[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b000, 3'b101};
    for (int n = 0; n < 40; n++) begin
      do_load(f3s[$urandom_range(0, 7)], $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_illegal();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

Load path counterpart of the store unit. Issues word-aligned read requests to data memory for RV32I loads (LB/LH/LW/LBU/LHU), waits on a request/acknowledge handshake, then extracts the addressed byte or halfword and sign- or zero-extends it. Sits between the execute-stage address/control signals and the register-file writeback mux, and stalls the pipeline while a read is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, number of REQ cycles without `mem_ack_in` before the load aborts with an error; legal values are 2..256.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  reset, asynchronous, active-high.
- op_for  input  3  operation class from control logic; 3'b001 = load, all other values are ignored.
- funct3_in  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other values are illegal.
- addr_in  input  32  effective byte address.
- mem_rd_req_out  output  1  read request to memory.
- mem_addr_out  output  32  {latched_addr[31:2], 2'b00}.
- mem_ack_in  input  1  memory acknowledge; `mem_data_in` is valid in the same cycle.
- mem_data_in  input  32  read word.
- load_data_out  output  32  aligned and extended result.
- load_valid_out  output  1  one-cycle pulse; `load_data_out` is valid.
- load_err_out  output  1  one-cycle pulse; the load was aborted.
- stall_out  output  1  pipeline must hold the current instruction.

## Operation
- The FSM has four states: IDLE, REQ, DONE and ERR. Reset enters IDLE.
- IDLE:
  - When `op_for`==001, latch `addr_in` and `funct3_in`.
  - If `funct3_in` is illegal (or the access is misaligned, see Configuration), go to ERR.
  - Otherwise go to REQ.
  - All other `op_for` values cause no action.
- REQ:
  - `mem_rd_req_out`=1, and `mem_addr_out` is driven from the latched address.
  - A timeout counter clears on entry and increments each cycle without an ack.
  - If `mem_ack_in`=1, capture the extracted result and go to DONE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, go to ERR.
  - An ack in the same cycle as the timeout limit takes priority, and the FSM goes to DONE.
- DONE: `load_valid_out`=1 and `load_data_out` is held. Go to IDLE. `op_for` is ignored in this state.
- ERR: `load_err_out`=1 and `load_data_out`=0. Go to IDLE.
- Extraction uses the latched `addr[1:0]`:
  - Byte = `mem_data_in[8*addr[1:0] +: 8]`.
  - Half = `mem_data_in[16*addr[1] +: 16]`.
  - Word = `mem_data_in`.
  - `funct3[2]`=0 sign-extends from the top bit of the byte or half; `funct3[2]`=1 zero-extends.
- `mem_ack_in` is ignored in IDLE, DONE and ERR.
- `stall_out` = (IDLE & `op_for`==001) | REQ. It is 0 in DONE and ERR, so the pipeline advances at the end of those cycles.
- `load_data_out` is registered and keeps its value until the next DONE or ERR.

## Timing
- Reset values:
  - State: IDLE.
  - `mem_rd_req_out`, `load_valid_out`, `load_err_out`: 0.
  - `load_data_out`, `mem_addr_out`, counter: 0.
  - `stall_out`: combinational. It is 0 during reset, because a held `op_for`==001 is only observed in IDLE after reset is released.
- Asserting reset mid-request drops `mem_rd_req_out` immediately (asynchronous). No valid or err pulse follows.
- Latency: the load is presented in cycle T. `mem_rd_req_out` is high from T+1. With an ack in T+1, `load_valid_out` pulses in T+2. A load therefore costs 2 stall cycles minimum, plus one per wait cycle.
- An illegal or misaligned load: stall in T, `load_err_out` in T+1, and no memory request is issued.
- Timeout: REQ lasts exactly TIMEOUT_CYCLES cycles, then ERR follows in the next cycle.
- Back-to-back loads: the next load can be presented in the cycle after DONE and is accepted.

## Configuration
- LOAD_MISALIGN_TRAP_EN
  - Defined: LH/LHU with `addr[0]`=1, or LW with `addr[1:0]`≠0, go IDLE→ERR without a request.
  - Undefined: no trap. LH/LHU ignore `addr[0]`, and LW ignores `addr[1:0]`.

## Test plan
- LB at `addr_in`=0x103, `mem_data_in`=0x80FF_1234, ack in first REQ cycle -> `load_data_out`=0xFFFF_FF80. `mem_addr_out`=0x100. `load_valid_out` at T+2. `stall_out` high for T and T+1.
- LHU at 0x202, data 0x8001_7FFF, ack after 3 wait cycles -> `load_data_out`=0x0000_8001, valid at T+5. LH under the same conditions -> 0xFFFF_8001.
- TIMEOUT_CYCLES=4, LW with no ack -> `mem_rd_req_out` high for 4 cycles, `load_err_out` pulses at T+5 with data 0. The next load presented at T+6 is accepted.
- `funct3_in`=011 -> no request, `load_err_out` at T+1. With LOAD_MISALIGN_TRAP_EN, LW at 0x101 -> err at T+1. Without it, LW at 0x101 reads word 0x100 and returns it unshifted.
- Reset asserted during REQ -> `mem_rd_req_out` falls the same cycle. A late ack after reset is released produces no valid pulse. Two back-to-back LWs each produce exactly one valid pulse.
